// File: rtl/fft_frame_sequencer_if.sv
// Handshake bundle between the frame sequencer and an FFT core:
// config channel, input sample stream, observed output stream and event flags.
interface fft_frame_sequencer_if;
    logic [7:0]  cfg_tdata;
    logic        cfg_tvalid;
    logic        cfg_tready;

    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;

    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;

    logic        evt_tlast_unexpected;
    logic        evt_tlast_missing;

    modport master (
        output cfg_tdata, cfg_tvalid,
        input  cfg_tready,
        output s_tdata, s_tvalid, s_tlast,
        input  s_tready,
        input  m_tvalid, m_tlast,
        output m_tready,
        input  evt_tlast_unexpected, evt_tlast_missing
    );

    modport slave (
        input  cfg_tdata, cfg_tvalid,
        output cfg_tready,
        input  s_tdata, s_tvalid, s_tlast,
        output s_tready,
        output m_tvalid, m_tlast,
        input  m_tready,
        output evt_tlast_unexpected, evt_tlast_missing
    );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Runs one FFT frame per start request: configures the core, streams N_POINT
// samples from a first-word-fall-through FIFO, then waits for the output tlast.
module fft_frame_sequencer #(
    parameter int unsigned N_POINT       = 1024,
    parameter logic [7:0]  CFG_WORD      = 8'h01,
    parameter int unsigned DRAIN_TIMEOUT = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         fifo_empty,
    input  logic [31:0]                  fifo_dout,
    output logic                         fifo_rd_en,
    fft_frame_sequencer_if.master        fft,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int unsigned      CNT_W    = $clog2(N_POINT);
    localparam int unsigned      TMR_W    = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_POINT - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DRAIN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONFIG,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] sample_cnt;
    logic [TMR_W-1:0] drain_cnt;

    logic start_accept;
    logic s_fire;
    logic frame_end;
    logic drain_hit;
    logic timeout_fire;
    logic evt_any;

    assign drain_hit = fft.m_tvalid && fft.m_tlast;
    assign evt_any   = fft.evt_tlast_unexpected || fft.evt_tlast_missing;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
        state_nxt      = state;
        start_accept   = 1'b0;
        s_fire         = 1'b0;
        frame_end      = 1'b0;
        timeout_fire   = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        fifo_rd_en     = 1'b0;
        fft.cfg_tvalid = 1'b0;
        fft.cfg_tdata  = '0;
        fft.s_tvalid   = 1'b0;
        fft.s_tdata    = '0;
        fft.s_tlast    = 1'b0;
        fft.m_tready   = !rst;

        // Outputs are held low while rst is high so nothing is popped or handshaken in that cycle.
        if (!rst) begin
            busy = (state != S_IDLE);
            done = (state == S_DONE);

            case (state)
                S_IDLE: begin
                    if (start) begin
                        start_accept = 1'b1;
                        state_nxt    = S_CONFIG;
                    end
                end

                S_CONFIG: begin
                    fft.cfg_tvalid = 1'b1;
                    fft.cfg_tdata  = CFG_WORD;
                    if (fft.cfg_tready) begin
                        state_nxt = S_STREAM;
                    end
                end

                S_STREAM: begin
                    fft.s_tvalid = !fifo_empty;
                    fft.s_tdata  = fifo_dout;
                    fft.s_tlast  = !fifo_empty && (sample_cnt == LAST_IDX);
                    s_fire       = !fifo_empty && fft.s_tready;
                    fifo_rd_en   = s_fire;
                    frame_end    = s_fire && (sample_cnt == LAST_IDX);
                    if (frame_end) begin
                        state_nxt = S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    if (drain_hit) begin
                        state_nxt = S_DONE;
                    end else if (drain_cnt == TMR_LAST) begin
                        timeout_fire = 1'b1;
                        state_nxt    = S_IDLE;
                    end
                end

                S_DONE: begin
                    state_nxt = S_IDLE;
                end

                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // The FSM register, counters and the sticky error all reset synchronously.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state is always updated with <= so every register samples pre-edge values.
            state      <= S_IDLE;
            sample_cnt <= '0;
            drain_cnt  <= '0;
            err        <= 1'b0;
        end else begin
            state <= state_nxt;

            if (start_accept) begin
                sample_cnt <= '0;
            end else if (s_fire) begin
                sample_cnt <= frame_end ? '0 : sample_cnt + CNT_W'(1);
            end

            if (state == S_DRAIN) begin
                drain_cnt <= drain_cnt + TMR_W'(1);
            end else begin
                drain_cnt <= '0;
            end

            // Clearing on an accepted start wins; events while idle are ignored.
            if (start_accept) begin
                err <= 1'b0;
            end else if (timeout_fire || (busy && evt_any)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench: two sequencers (drain timeout 64 and 16) share stimulus and a
// modelled FWFT FIFO whose sample at read pointer p is 32'hA000_0000 + p.
module tb_fft_frame_sequencer;

    logic clk;
    logic rst;
    logic start;
    logic cfg_tready;
    logic s_tready;
    logic m_tvalid;
    logic m_tlast;
    logic evt_unexp;
    logic evt_miss;
    logic force_empty;

    logic        fifo_empty;
    logic [31:0] fifo_dout;
    logic        rd_a, rd_b;
    logic        busy_a, done_a, err_a;
    logic        busy_b, done_b, err_b;
    logic [7:0]  outs_a, outs_b;

    int unsigned rd_ptr = 0;
    int unsigned wr_ptr = 0;
    int checks   = 0;
    int failures = 0;

    fft_frame_sequencer_if if_a ();
    fft_frame_sequencer_if if_b ();

    assign if_a.cfg_tready           = cfg_tready;
    assign if_a.s_tready             = s_tready;
    assign if_a.m_tvalid             = m_tvalid;
    assign if_a.m_tlast              = m_tlast;
    assign if_a.evt_tlast_unexpected = evt_unexp;
    assign if_a.evt_tlast_missing    = evt_miss;
    assign if_b.cfg_tready           = cfg_tready;
    assign if_b.s_tready             = s_tready;
    assign if_b.m_tvalid             = m_tvalid;
    assign if_b.m_tlast              = m_tlast;
    assign if_b.evt_tlast_unexpected = evt_unexp;
    assign if_b.evt_tlast_missing    = evt_miss;

    fft_frame_sequencer #(.N_POINT(8), .CFG_WORD(8'h01), .DRAIN_TIMEOUT(64)) dut_a (
        .clk(clk), .rst(rst), .start(start), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(rd_a), .fft(if_a.master), .busy(busy_a), .done(done_a), .err(err_a)
    );

    fft_frame_sequencer #(.N_POINT(8), .CFG_WORD(8'h01), .DRAIN_TIMEOUT(16)) dut_b (
        .clk(clk), .rst(rst), .start(start), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(rd_b), .fft(if_b.master), .busy(busy_b), .done(done_b), .err(err_b)
    );

    assign fifo_empty = (rd_ptr == wr_ptr) || force_empty;
    assign fifo_dout  = 32'hA000_0000 + rd_ptr;
    assign outs_a = {busy_a, done_a, err_a, if_a.cfg_tvalid, if_a.s_tvalid, if_a.s_tlast, rd_a, if_a.m_tready};
    assign outs_b = {busy_b, done_b, err_b, if_b.cfg_tvalid, if_b.s_tvalid, if_b.s_tlast, rd_b, if_b.m_tready};

    always @(posedge clk) begin
        if (rd_a === 1'b1) rd_ptr <= rd_ptr + 1;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; start = 1'b0; cfg_tready = 1'b1; s_tready = 1'b1;
        m_tvalid = 1'b0; m_tlast = 1'b0; evt_unexp = 1'b0; evt_miss = 1'b0; force_empty = 1'b0;
        tick();
        tick();
        wr_ptr = rd_ptr;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        rst = 1'b1;
        tick();
        #1;
        if (outs_a !== 8'h00) begin failures++; $display("FAIL reset_outs_a got=%b exp=00000000", outs_a); end
        checks++;
        if (outs_b !== 8'h00) begin failures++; $display("FAIL reset_outs_b got=%b exp=00000000", outs_b); end
        checks++;
        if (if_a.cfg_tdata !== 8'h00 || if_a.s_tdata !== 32'h0) begin
            failures++; $display("FAIL reset_data got=%h/%h exp=0/0", if_a.cfg_tdata, if_a.s_tdata);
        end
        checks++;
        rst = 1'b0;
        #1;
        if ({busy_a, if_a.m_tready} !== 2'b01) begin failures++; $display("FAIL idle_after_reset got=%b exp=01", {busy_a, if_a.m_tready}); end
        checks++;
    endtask

    task automatic test_single_frame();
        int unsigned base;
        apply_reset();
        base = rd_ptr;
        wr_ptr = rd_ptr + 8;
        start = 1'b1;
        #1;
        if (busy_a !== 1'b0) begin failures++; $display("FAIL main_busy_before got=%b exp=0", busy_a); end
        checks++;
        tick();
        start = 1'b0;
        #1;
        if ({if_a.cfg_tvalid, if_a.cfg_tdata, busy_a, rd_a} !== {1'b1, 8'h01, 1'b1, 1'b0}) begin
            failures++; $display("FAIL main_config got=%b_%h_%b_%b exp=1_01_1_0", if_a.cfg_tvalid, if_a.cfg_tdata, busy_a, rd_a);
        end
        checks++;
        tick();
        for (int i = 0; i < 8; i++) begin
            #1;
            if ({if_a.cfg_tvalid, if_a.s_tvalid, rd_a, if_a.s_tlast} !== {1'b0, 1'b1, 1'b1, (i == 7)}) begin
                failures++; $display("FAIL main_stream_%0d got=%b%b%b%b exp=011%0b", i, if_a.cfg_tvalid, if_a.s_tvalid, rd_a, if_a.s_tlast, (i == 7));
            end
            checks++;
            if (if_a.s_tdata !== 32'hA000_0000 + base + i) begin
                failures++; $display("FAIL main_data_%0d got=%h exp=%h", i, if_a.s_tdata, 32'hA000_0000 + base + i);
            end
            checks++;
            tick();
        end
        for (int k = 0; k < 19; k++) begin
            m_tvalid = (k == 5);
            m_tlast  = 1'b0;
            #1;
            if ({busy_a, done_a, rd_a} !== 3'b100) begin failures++; $display("FAIL main_drain_%0d got=%b exp=100", k, {busy_a, done_a, rd_a}); end
            checks++;
            tick();
        end
        m_tvalid = 1'b1;
        m_tlast  = 1'b1;
        tick();
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        #1;
        if ({busy_a, done_a, err_a} !== 3'b110) begin failures++; $display("FAIL main_done got=%b exp=110", {busy_a, done_a, err_a}); end
        checks++;
        tick();
        #1;
        if ({busy_a, done_a} !== 2'b00) begin failures++; $display("FAIL main_after_done got=%b exp=00", {busy_a, done_a}); end
        checks++;
        if (rd_ptr - base !== 8) begin failures++; $display("FAIL main_pops got=%0d exp=8", rd_ptr - base); end
        checks++;
    endtask

    task automatic test_stall();
        int unsigned base;
        int xfers;
        int c;
        apply_reset();
        base = rd_ptr;
        wr_ptr = rd_ptr + 8;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        xfers = 0;
        c = 0;
        while (xfers < 8 && c < 80) begin
            s_tready    = (c % 2 == 0);
            force_empty = (c >= 5 && c < 10);
            #1;
            if (rd_a !== (if_a.s_tvalid && s_tready) || (rd_a === 1'b1 && !s_tready)) begin
                failures++; $display("FAIL stall_rd_en_c%0d got=%b s_tready=%b", c, rd_a, s_tready);
            end
            checks++;
            if (force_empty && if_a.s_tvalid !== 1'b0) begin
                failures++; $display("FAIL stall_valid_empty_c%0d got=%b exp=0", c, if_a.s_tvalid);
            end
            if (force_empty) checks++;
            if (if_a.s_tvalid === 1'b1) begin
                if (if_a.s_tlast !== (xfers == 7)) begin
                    failures++; $display("FAIL stall_tlast_c%0d got=%b exp=%0b", c, if_a.s_tlast, (xfers == 7));
                end
                checks++;
                if (if_a.s_tdata !== 32'hA000_0000 + base + xfers) begin
                    failures++; $display("FAIL stall_data_c%0d got=%h exp=%h", c, if_a.s_tdata, 32'hA000_0000 + base + xfers);
                end
                checks++;
                if (s_tready) xfers++;
            end
            tick();
            c++;
        end
        if (xfers !== 8) begin failures++; $display("FAIL stall_xfers got=%0d exp=8", xfers); end
        checks++;
        s_tready    = 1'b1;
        force_empty = 1'b0;
        wr_ptr      = rd_ptr + 4;
        #1;
        if ({busy_a, if_a.s_tvalid, rd_a} !== 3'b100) begin failures++; $display("FAIL stall_drain got=%b exp=100", {busy_a, if_a.s_tvalid, rd_a}); end
        checks++;
        repeat (3) tick();
        if (rd_ptr - base !== 8) begin failures++; $display("FAIL stall_pops got=%0d exp=8", rd_ptr - base); end
        checks++;
        m_tvalid = 1'b1;
        m_tlast  = 1'b1;
        tick();
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        #1;
        if (done_a !== 1'b1) begin failures++; $display("FAIL stall_done got=%b exp=1", done_a); end
        checks++;
    endtask

    task automatic test_timeout();
        apply_reset();
        wr_ptr = rd_ptr + 8;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        for (int k = 1; k <= 16; k++) begin
            #1;
            if ({busy_b, err_b, done_b} !== 3'b100) begin failures++; $display("FAIL timeout_drain_%0d got=%b exp=100", k, {busy_b, err_b, done_b}); end
            checks++;
            tick();
        end
        #1;
        if ({busy_b, err_b, done_b} !== 3'b010) begin failures++; $display("FAIL timeout_expire got=%b exp=010", {busy_b, err_b, done_b}); end
        checks++;
        tick();
        #1;
        if ({busy_b, err_b, done_b} !== 3'b010) begin failures++; $display("FAIL timeout_sticky got=%b exp=010", {busy_b, err_b, done_b}); end
        checks++;
        if ({busy_a, err_a} !== 2'b10) begin failures++; $display("FAIL timeout_long_still_drain got=%b exp=10", {busy_a, err_a}); end
        checks++;
    endtask

    task automatic test_event_err();
        int unsigned base;
        apply_reset();
        base = rd_ptr;
        wr_ptr = rd_ptr + 8;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            evt_miss = (i == 3);
            tick();
        end
        evt_miss = 1'b0;
        #1;
        if ({busy_a, err_a} !== 2'b11) begin failures++; $display("FAIL evt_err_set got=%b exp=11", {busy_a, err_a}); end
        checks++;
        if (rd_ptr - base !== 8) begin failures++; $display("FAIL evt_pops got=%0d exp=8", rd_ptr - base); end
        checks++;
        m_tvalid = 1'b1;
        m_tlast  = 1'b1;
        tick();
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        #1;
        if ({done_a, err_a} !== 2'b11) begin failures++; $display("FAIL evt_done got=%b exp=11", {done_a, err_a}); end
        checks++;
        tick();
        #1;
        if ({busy_a, err_a} !== 2'b01) begin failures++; $display("FAIL evt_err_held got=%b exp=01", {busy_a, err_a}); end
        checks++;
        wr_ptr = rd_ptr + 8;
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        if ({if_a.cfg_tvalid, err_a} !== 2'b10) begin failures++; $display("FAIL evt_err_cleared got=%b exp=10", {if_a.cfg_tvalid, err_a}); end
        checks++;
    endtask

    task automatic test_reset_mid_frame();
        int unsigned base;
        apply_reset();
        base = rd_ptr;
        wr_ptr = rd_ptr + 8;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        if (if_a.m_tready !== 1'b0) begin failures++; $display("FAIL rstmid_m_tready got=%b exp=0", if_a.m_tready); end
        checks++;
        tick();
        #1;
        if (outs_a !== 8'h00) begin failures++; $display("FAIL rstmid_outs got=%b exp=00000000", outs_a); end
        checks++;
        if (rd_ptr - base !== 4) begin failures++; $display("FAIL rstmid_pops got=%0d exp=4", rd_ptr - base); end
        checks++;
        rst = 1'b0;
        start = 1'b1;
        base = rd_ptr;
        wr_ptr = rd_ptr + 8;
        tick();
        start = 1'b0;
        #1;
        if (if_a.cfg_tvalid !== 1'b1) begin failures++; $display("FAIL rstmid_restart got=%b exp=1", if_a.cfg_tvalid); end
        checks++;
        tick();
        for (int i = 0; i < 8; i++) begin
            #1;
            if ({rd_a, if_a.s_tlast} !== {1'b1, (i == 7)} || if_a.s_tdata !== 32'hA000_0000 + base + i) begin
                failures++; $display("FAIL rstmid_xfer_%0d got=%b%b/%h exp=1%0b/%h", i, rd_a, if_a.s_tlast, if_a.s_tdata, (i == 7), 32'hA000_0000 + base + i);
            end
            checks++;
            tick();
        end
        m_tvalid = 1'b1;
        m_tlast  = 1'b1;
        tick();
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        #1;
        if (done_a !== 1'b1) begin failures++; $display("FAIL rstmid_done got=%b exp=1", done_a); end
        checks++;
    endtask

    task automatic test_back_to_back();
        int unsigned base;
        apply_reset();
        base = rd_ptr;
        wr_ptr = rd_ptr + 16;
        start = 1'b1;
        repeat (10) tick();
        m_tvalid = 1'b1;
        m_tlast  = 1'b1;
        tick();
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        #1;
        if ({done_a, if_a.s_tvalid, rd_a} !== 3'b100) begin failures++; $display("FAIL b2b_done got=%b exp=100", {done_a, if_a.s_tvalid, rd_a}); end
        checks++;
        if (rd_ptr - base !== 8) begin failures++; $display("FAIL b2b_pops got=%0d exp=8", rd_ptr - base); end
        checks++;
        cfg_tready = 1'b0;
        tick();
        #1;
        if ({busy_a, done_a} !== 2'b00) begin failures++; $display("FAIL b2b_idle got=%b exp=00", {busy_a, done_a}); end
        checks++;
        tick();
        start = 1'b0;
        #1;
        if ({busy_a, if_a.cfg_tvalid} !== 2'b11) begin failures++; $display("FAIL b2b_second_cfg got=%b exp=11", {busy_a, if_a.cfg_tvalid}); end
        checks++;
        tick();
        #1;
        if ({if_a.cfg_tvalid, if_a.s_tvalid, rd_a} !== 3'b100) begin failures++; $display("FAIL b2b_cfg_wait got=%b exp=100", {if_a.cfg_tvalid, if_a.s_tvalid, rd_a}); end
        checks++;
        cfg_tready = 1'b1;
        tick();
        #1;
        if (if_a.s_tvalid !== 1'b1 || if_a.s_tdata !== 32'hA000_0000 + base + 8) begin
            failures++; $display("FAIL b2b_second_stream got=%b/%h exp=1/%h", if_a.s_tvalid, if_a.s_tdata, 32'hA000_0000 + base + 8);
        end
        checks++;
        apply_reset();
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_stall();
        test_timeout();
        test_event_err();
        test_reset_mid_frame();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_frame_sequencer.md
FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

Interface
REQ-001 SHALL provide parameter N_POINT, default 1024, meaning samples per FFT frame (power of 2, 8..65536).
REQ-002 SHALL provide parameter CFG_WORD, default 8'h01, meaning config word sent to the FFT core (bit0=1 forward transform).
REQ-003 SHALL provide parameter DRAIN_TIMEOUT, default 4096, meaning maximum cycles spent waiting for the output tlast.
REQ-004 SHALL have port clk  in  1  single clock for all logic.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  in  1  one-cycle request to process one frame.
REQ-007 SHALL have port fifo_empty  in  1  sample FIFO empty flag (first-word-fall-through FIFO).
REQ-008 SHALL have port fifo_dout  in  32  current FIFO head sample.
REQ-009 SHALL have port fifo_rd_en  out  1  pop FIFO head.
REQ-010 SHALL have ports cfg_tdata out 8, cfg_tvalid out 1, cfg_tready in 1, forming the FFT config channel.
REQ-011 SHALL have ports s_tdata out 32, s_tvalid out 1, s_tready in 1, s_tlast out 1, forming the FFT input data channel.
REQ-012 SHALL have ports m_tvalid in 1, m_tlast in 1, m_tready out 1, observing the FFT output channel.
REQ-013 SHALL have ports evt_tlast_unexpected in 1 and evt_tlast_missing in 1, carrying the FFT event flags.
REQ-014 SHALL have ports busy out 1, done out 1 (one-cycle pulse), err out 1 (sticky).

Function
REQ-015 SHALL implement the FSM IDLE -> CONFIG -> STREAM -> DRAIN -> DONE -> IDLE.
REQ-016 IDLE: when start=1, SHALL clear err and the sample counter and go to CONFIG; when start=0, SHALL remain in IDLE.
REQ-017 CONFIG: SHALL drive cfg_tvalid=1 with cfg_tdata=CFG_WORD, and on a cycle with cfg_tvalid&cfg_tready SHALL go to STREAM; cfg_tvalid SHALL be 0 in all other states.
REQ-018 STREAM: SHALL drive s_tvalid=!fifo_empty and s_tdata=fifo_dout combinationally, and SHALL assert fifo_rd_en exactly when s_tvalid&s_tready.
REQ-019 STREAM: sample counter (log2(N_POINT) bits) SHALL increment on each s_tvalid&s_tready transfer; s_tlast SHALL equal s_tvalid&(counter==N_POINT-1).
REQ-020 The transfer carrying s_tlast SHALL move the FSM to DRAIN and return the counter to 0; no more than N_POINT samples SHALL be popped per frame.
REQ-021 FIFO empty mid-frame: s_tvalid SHALL drop, the counter SHALL hold, and the frame SHALL continue when data returns; no timeout applies in STREAM.
REQ-022 m_tready SHALL be 1 in every state except while rst=1.
REQ-023 DRAIN: on m_tvalid&m_tlast SHALL go to DONE; if DRAIN_TIMEOUT cycles elapse without it, SHALL set err and go to IDLE without a done pulse.
REQ-024 DONE: SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-025 busy SHALL be 1 in CONFIG, STREAM, DRAIN and DONE, and 0 in IDLE.
REQ-026 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-027 evt_tlast_unexpected or evt_tlast_missing asserted while busy SHALL set err; the frame SHALL still complete normally.
REQ-028 err SHALL hold until rst or the next accepted start.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE, zero the counters, and clear err, done, busy, cfg_tvalid, s_tvalid, s_tlast, fifo_rd_en and m_tready, including mid-frame; no partial-frame state SHALL survive.
REQ-030 The first start SHALL be accepted on the cycle after rst deasserts.

Verification
REQ-031 N_POINT=8, FIFO holds 8 samples, cfg_tready=s_tready=1, start pulse -> cfg handshake in 1 cycle, then 8 pops on consecutive cycles, s_tlast only on the 8th; m_tlast 20 cycles later -> done pulse for one cycle, busy=0 afterwards.
REQ-032 s_tready toggling 1/0 and fifo_empty=1 for 5 cycles mid-frame -> exactly 8 transfers, counter holds while stalled, fifo_rd_en never asserted with s_tready=0.
REQ-033 DRAIN_TIMEOUT=16 and m_tlast never asserted -> err=1 at cycle 16 of DRAIN, FSM returns to IDLE, no done pulse.
REQ-034 evt_tlast_missing pulse during STREAM -> err=1 and the frame still ends with done; the next start clears err.
REQ-035 rst asserted after the 4th transfer -> next cycle all outputs are 0 except m_tready=0 during reset; a following start runs a full 8-sample frame.
REQ-036 start held high across a whole frame -> a second frame begins only from IDLE after done; no extra pops occur during DONE.
